// File: rtl/crono_pkg.sv
// Shared types and default timing constants for the stopwatch button front end.
package crono_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHORT = 2'd1,
    LONG  = 2'd2
  } btn_state_t;

  localparam int CLK_HZ = 100_000_000;

  // 10 ms of stable level to accept a change, 1 s of hold for a long press
  localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;
  localparam int LONG_CYCLES_DEF     = CLK_HZ;

endpackage

// File: rtl/crono_debounce.sv
// Two-flop synchroniser followed by a stability counter; dout_d exposes the
// level dout will take on the next clock so the caller can act on the same edge.
module crono_debounce
  import crono_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic dout_d
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *) logic sync1_q;
  logic          sync2_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          dout_q;
  logic          dout_next;

  // Any cycle where the synchronised level agrees with dout restarts the count
  always_comb begin
    cnt_d     = '0;
    dout_next = dout_q;
    if (sync2_q != dout_q) begin
      if (cnt_q == CNT_LAST) begin
        dout_next = ~dout_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      dout_q  <= dout_next;
    end
  end

  assign dout   = dout_q;
  assign dout_d = dout_next;

endmodule

// File: rtl/crono_button_ctrl.sv
// Stopwatch button front end: short press toggles run, long press while stopped clears.
// Define CRONO_LAP_EN to add the lap button with freeze/lap outputs.
module crono_button_ctrl
  import crono_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
`ifdef CRONO_LAP_EN
  input  logic lap_button,
  output logic lap,
  output logic freeze,
`endif
  output logic pressed,
  output logic running,
  output logic clear,
  output logic ready
);

  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

  btn_state_t    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          running_q, running_d;
  logic          clear_q, clear_d;
  logic          ready_q;
  logic          pressed_next;

  crono_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_db (
    .clk   (clk),
    .rst   (rst),
    .din   (button),
    .dout  (pressed),
    .dout_d(pressed_next)
  );

  // The FSM reacts to the debounced level it is about to take, so the run
  // toggle lands on the same edge that pressed falls.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    running_d = running_q;
    clear_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pressed_next && !pressed) begin
          state_d = SHORT;
          hold_d  = '0;
        end
      end
      SHORT: begin
        if (!pressed_next) begin
          state_d   = IDLE;
          running_d = ~running_q;
        end else begin
          if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
          end
          if (hold_q == HOLD_LAST) begin
            state_d = LONG;
            clear_d = ~running_q;
          end
        end
      end
      LONG: begin
        if (!pressed_next) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      running_q <= 1'b0;
      clear_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      running_q <= running_d;
      clear_q   <= clear_d;
      ready_q   <= 1'b1;
    end
  end

  assign running = running_q;
  assign clear   = clear_q;
  assign ready   = ready_q;

`ifdef CRONO_LAP_EN
  logic lap_pressed;
  logic lap_pressed_next;
  logic lap_rise;
  logic freeze_q, freeze_d;
  logic lap_q, lap_d;

  crono_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_lap_db (
    .clk   (clk),
    .rst   (rst),
    .din   (lap_button),
    .dout  (lap_pressed),
    .dout_d(lap_pressed_next)
  );

  assign lap_rise = lap_pressed_next && !lap_pressed;

  // A clear wipes the frozen display along with the counters
  always_comb begin
    freeze_d = freeze_q;
    lap_d    = 1'b0;
    if (clear_d) begin
      freeze_d = 1'b0;
    end else if (lap_rise && running_q) begin
      freeze_d = ~freeze_q;
      lap_d    = 1'b1;
    end else if (lap_rise && freeze_q) begin
      freeze_d = 1'b0;
      lap_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      freeze_q <= 1'b0;
      lap_q    <= 1'b0;
    end else begin
      freeze_q <= freeze_d;
      lap_q    <= lap_d;
    end
  end

  assign freeze = freeze_q;
  assign lap    = lap_q;
`endif

endmodule

// File: tb/tb_crono_button_ctrl.sv
// Directed self-checking bench for crono_button_ctrl with short debounce/hold times.
module tb_crono_button_ctrl;

  localparam int DB   = 4;
  localparam int LONG = 20;

  logic clk;
  logic rst;
  logic button;
  logic pressed;
  logic running;
  logic clear;
  logic ready;

  int checksTotal  = 0;
  int checksPassed = 0;
  int clearCount   = 0;

  crono_button_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LONG)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .button (button),
    .pressed(pressed),
    .running(running),
    .clear  (clear),
    .ready  (ready)
  );

  // 100 MHz clock; the DUT acts on the rising edge, the bench works on the falling one
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which clear is high, sampled just after the rising edge
  always @(posedge clk) begin
    #1;
    if (clear === 1'b1) clearCount = clearCount + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive the raw button to a level and hold it for a number of cycles
  task automatic applyStimulus(input logic level, input int cycles);
    button = level;
    tick(cycles);
  endtask

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checksTotal = checksTotal + 1;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end else begin
      checksPassed = checksPassed + 1;
    end
  endtask

  initial begin
    rst    = 1'b0;
    button = 1'b0;

    // Reset held for three clocks, then released between edges
    tick(3);
    checkOutput("rst_pressed", pressed, 0);
    checkOutput("rst_running", running, 0);
    checkOutput("rst_clear", clear, 0);
    checkOutput("rst_ready", ready, 0);
    rst = 1'b1;
    tick(1);
    checkOutput("ready_first_clk", ready, 1);
    checkOutput("post_rst_running", running, 0);

    // Bounces of 1, 2 and 3 cycles must never reach pressed
    begin
      int sawPressed;
      int bounceLen[6];
      logic bounceLvl[6];
      bounceLen = '{1, 1, 2, 1, 3, 12};
      bounceLvl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      sawPressed = 0;
      for (int i = 0; i < 6; i++) begin
        button = bounceLvl[i];
        for (int c = 0; c < bounceLen[i]; c++) begin
          tick(1);
          if (pressed === 1'b1) sawPressed = 1;
        end
      end
      checkOutput("bounce_pressed", sawPressed, 0);
      checkOutput("bounce_running", running, 0);
    end

    // Short press: pressed rises 6 clocks after raw edge, running 6 after release
    clearCount = 0;
    applyStimulus(1'b1, 5);
    checkOutput("short_pressed_5", pressed, 0);
    tick(1);
    checkOutput("short_pressed_6", pressed, 1);
    tick(4);
    applyStimulus(1'b0, 5);
    checkOutput("short_run_5", running, 0);
    checkOutput("short_held_5", pressed, 1);
    tick(1);
    checkOutput("short_run_6", running, 1);
    checkOutput("short_released", pressed, 0);
    tick(5);
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 10);
    checkOutput("short2_running", running, 0);
    checkOutput("short_no_clear", clearCount, 0);

    // Long press while stopped: one clear cycle 20 clocks after pressed rises
    clearCount = 0;
    applyStimulus(1'b1, 6);
    checkOutput("long_pressed", pressed, 1);
    tick(19);
    checkOutput("long_clear_early", clear, 0);
    tick(1);
    checkOutput("long_clear_on", clear, 1);
    tick(1);
    checkOutput("long_clear_off", clear, 0);
    tick(13);
    applyStimulus(1'b0, 10);
    checkOutput("long_running", running, 0);
    checkOutput("long_clear_count", clearCount, 1);

    // Long press while running is ignored
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 10);
    checkOutput("lr_start_running", running, 1);
    clearCount = 0;
    applyStimulus(1'b1, 40);
    applyStimulus(1'b0, 10);
    checkOutput("lr_no_clear", clearCount, 0);
    checkOutput("lr_running", running, 1);

    // Reset while the button is held at hold-count 10
    applyStimulus(1'b1, 16);
    rst = 1'b0;
    #1;
    checkOutput("midrst_running", running, 0);
    checkOutput("midrst_pressed", pressed, 0);
    checkOutput("midrst_ready", ready, 0);
    tick(2);
    rst = 1'b1;
    clearCount = 0;
    tick(25);
    checkOutput("midrst_clear_early", clearCount, 0);
    tick(1);
    checkOutput("midrst_clear_on", clear, 1);
    tick(1);
    checkOutput("midrst_clear_off", clear, 0);
    applyStimulus(1'b0, 10);
    checkOutput("midrst_running_end", running, 0);
    checkOutput("midrst_clear_count", clearCount, 1);
    checkOutput("midrst_ready_end", ready, 1);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/crono_button_ctrl.md
Name: crono_button_ctrl

Overview:
Front-end control stage for the stopwatch. It synchronises and debounces the raw push-button and classifies each press as short or long.
- Short press toggles the run state.
- Long press while stopped emits a one-cycle clear to zero the digit counters.
- Outputs drive the counter-chain enable and clear directly; the multiplexed display stage is unaffected.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before the debounced level changes (10 ms at 100 MHz)
LONG_CYCLES, 100000000, debounced-hold cycles that qualify a press as long (1 s at 100 MHz)

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  reset; asynchronous assert, active-low (0 = reset)
button  input  1  raw asynchronous push-button, 1 = pressed
pressed  output  1  debounced button level
running  output  1  counter-chain enable; 1 = counting
clear  output  1  one-cycle pulse; zeroes all digit counters
ready  output  1  0 in reset, 1 from first clock after reset release

Behaviour:
- One clock domain. Every flop clears asynchronously when rst=0.
- Reset values: pressed=0, running=0, clear=0, ready=0, all counters 0, FSM=IDLE.
- Synchroniser:
  - Two flops in series; first stage marked ASYNC_REG.
  - Synchronised level is button_s.
- Debounce:
  - Counter width $clog2(DEBOUNCE_CYCLES+1). Counter increments while button_s != pressed.
  - Counter resets to 0 on any cycle where button_s == pressed.
  - When the count reaches DEBOUNCE_CYCLES-1 with the mismatch still present, pressed flips and the counter resets.
  - Latency from a clean raw edge to pressed change is exactly DEBOUNCE_CYCLES+2 clocks.
  - A glitch shorter than DEBOUNCE_CYCLES never reaches pressed.
- FSM states: IDLE, SHORT, LONG.
  - IDLE: pressed rises -> SHORT; hold counter cleared.
  - SHORT: hold counter increments each cycle, saturating at LONG_CYCLES. Width is $clog2(LONG_CYCLES+1).
    - pressed falls before the count reaches LONG_CYCLES-1 -> IDLE; running toggles on that same edge.
    - Count reaches LONG_CYCLES-1 while still pressed -> LONG. If running==0, clear=1 for exactly that cycle.
  - LONG: wait for pressed to fall -> IDLE. No toggle, no clear.
    - A long press while running is ignored entirely.
- clear is never asserted for more than one cycle per press.
- running never toggles on a press that qualified as long.
- Simultaneous events:
  - The release edge and the LONG threshold cannot coincide, because the threshold is checked only while pressed=1.
- Reset mid-press: FSM returns to IDLE and running=0.
  - If the button is still held after rst releases, pressed rises after debounce and a normal press cycle begins.
- ready goes 1 on the first rising clk after rst deasserts, then stays 1.

Optional Feature:
Macro: CRONO_LAP_EN.
- Defined:
  - Adds input lap_button (raw) and outputs lap (1 bit) and freeze (1 bit). lap_button uses an identical synchroniser and debouncer.
  - A debounced rising edge of the lap button while running=1 toggles freeze.
  - A debounced rising edge while running=0 with freeze=1 clears freeze.
  - lap pulses 1 cycle on each freeze toggle.
  - freeze resets to 0 and clears together with clear.
  - The display stage holds its last value while freeze=1; the counters keep running.
- Undefined:
  - Ports lap_button, lap and freeze do not exist.
  - No additional logic.

Decomposition:
- Package crono_pkg holds:
  - typedef enum logic [1:0] btn_state_t {IDLE, SHORT, LONG};
  - localparam CLK_HZ = 100_000_000;
  - default DEBOUNCE_CYCLES and LONG_CYCLES derived from CLK_HZ.
- One sub-module, crono_debounce (synchroniser + debounce counter; ports clk, rst, din, dout).
  - Instantiated once, or twice when CRONO_LAP_EN is defined.

Test Plan:
Bench uses DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
1. Reset: hold rst=0 for 3 clocks, then release -> pressed=0, running=0, clear=0; ready=1 on the first clock after release.
2. Bounce: button pulses of 1, 2 and 3 cycles separated by 1-cycle gaps, then low -> pressed stays 0; running stays 0.
3. Short press: button high for 10 cycles, then low -> pressed rises 6 clocks after the raw edge; running=1 exactly 6 clocks after the raw falling edge. Repeat -> running=0.
4. Long press while stopped: button high 40 cycles -> clear=1 for exactly one cycle, 20 clocks after pressed rises; running stays 0 after release.
5. Long press while running: start running with test 3, then hold 40 cycles -> clear never asserts; running stays 1 after release.
6. Reset mid-press: assert rst=0 at hold-count 10 with button still high, then release -> running=0; clear=1 occurs 6+20 clocks after reset release, unless the button is released first.
